// File: rtl/alu_muldiv_seq_if.sv
// Operand, control and result bundle between the EX-stage control FSM and the
// multicycle RV32M unit; the EX stage is the master, the unit is the slave.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             kill;
    logic [WIDTH-1:0] data_in_1;
    logic [WIDTH-1:0] data_in_2;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output start, kill, data_in_1, data_in_2, opcode, func3, func7,
        input  data_out, busy, done, zero
    );

    modport slave (
        input  start, kill, data_in_1, data_in_2, opcode, func3, func7,
        output data_out, busy, done, zero
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 RV32M unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per clock, with a sign fix-up pass at the end.
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic              clk,
    input logic              rst_n,
    alu_muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [6:0]       OP_REG   = 7'b0110011;
    localparam logic [6:0]       FUNC7_M  = 7'b0000001;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [2:0]         func3_q, func3_d;
    logic               resNeg_q, resNeg_d;
    logic               remNeg_q, remNeg_d;
    logic [WIDTH-1:0]   dataOut_q, dataOut_d;

    logic               accept;
    logic               isDivIn;
    logic               signed1, signed2;
    logic               neg1, neg2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic               divZero, divOverflow;
    logic [WIDTH-1:0]   specialResult;

    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fixResult;

    // Operand decode: sign flags, magnitudes and the cases that bypass iteration
    always_comb begin
        accept  = (state_q == IDLE) && bus.start && (bus.opcode == OP_REG) &&
                  (bus.func7 == FUNC7_M) && !bus.kill;
        isDivIn = bus.func3[2];
        signed1 = (bus.func3 == 3'b001) || (bus.func3 == 3'b010) ||
                  (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
        signed2 = (bus.func3 == 3'b001) || (bus.func3 == 3'b100) ||
                  (bus.func3 == 3'b110);
        neg1    = signed1 && bus.data_in_1[WIDTH-1];
        neg2    = signed2 && bus.data_in_2[WIDTH-1];
        mag1    = neg1 ? -bus.data_in_1 : bus.data_in_1;
        mag2    = neg2 ? -bus.data_in_2 : bus.data_in_2;
        divZero = isDivIn && (bus.data_in_2 == '0);
        divOverflow = isDivIn && !bus.func3[0] && (bus.data_in_1 == MOST_NEG) &&
                      (&bus.data_in_2);
        if (divZero) begin
            specialResult = bus.func3[1] ? bus.data_in_1 : '1;
        end else begin
            specialResult = bus.func3[1] ? '0 : bus.data_in_1;
        end
    end

    // One iteration of each datapath plus the final sign correction
    always_comb begin
        mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opB_q : '0)};
        mulNext   = {mulSum, acc_q[WIDTH-1:1]};
        divShift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        divDiff   = divShift - {1'b0, opB_q};
        divNext   = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prodFixed = resNeg_q ? -acc_q : acc_q;
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
        if (!func3_q[2]) begin
            fixResult = (func3_q == 3'b000) ? prodFixed[WIDTH-1:0]
                                            : prodFixed[2*WIDTH-1:WIDTH];
        end else if (func3_q[1]) begin
            fixResult = remNeg_q ? -rem : rem;
        end else begin
            fixResult = resNeg_q ? -quo : quo;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opB_d     = opB_q;
        func3_d   = func3_q;
        resNeg_d  = resNeg_q;
        remNeg_d  = remNeg_q;
        dataOut_d = dataOut_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    func3_d  = bus.func3;
                    resNeg_d = neg1 ^ neg2;
                    remNeg_d = neg1;
                    if (isDivIn) begin
                        acc_d = {{WIDTH{1'b0}}, mag1};
                        opB_d = mag2;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag2};
                        opB_d = mag1;
                    end
                    if (divZero || divOverflow) begin
                        dataOut_d = specialResult;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = func3_q[2] ? divNext : mulNext;
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            FIX: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    dataOut_d = fixResult;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            func3_q   <= '0;
            resNeg_q  <= 1'b0;
            remNeg_q  <= 1'b0;
            dataOut_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opB_q     <= opB_d;
            func3_q   <= func3_d;
            resNeg_q  <= resNeg_d;
            remNeg_q  <= remNeg_d;
            dataOut_q <= dataOut_d;
        end
    end

    assign bus.data_out = dataOut_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.zero     = (dataOut_q == '0);
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: a vector table run on a 32-bit and a
// 16-bit instance, then hand sequences for kill, start handling and reset.
module tb_alu_muldiv_seq;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] F7_M = 7'b0000001;
    localparam int NVEC = 30;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq_if #(.WIDTH(32)) b32();
    alu_muldiv_seq_if #(.WIDTH(16)) b16();

    alu_muldiv_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_muldiv_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    typedef struct {
        bit          narrow;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(input bit n, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] e, input int c);
        vec_t v;
        v.narrow = n;
        v.f3     = f;
        v.a      = a;
        v.b      = b;
        v.exp    = e;
        v.cyc    = c;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        b32.start = 1'b0; b32.kill = 1'b0; b32.opcode = OP_R; b32.func7 = F7_M;
        b32.func3 = 3'b000; b32.data_in_1 = '0; b32.data_in_2 = '0;
        b16.start = 1'b0; b16.kill = 1'b0; b16.opcode = OP_R; b16.func7 = F7_M;
        b16.func3 = 3'b000; b16.data_in_1 = '0; b16.data_in_2 = '0;
    endtask

    // Launch one op, scramble operands after the accept edge, then wait for done
    task automatic applyStimulus(input bit narrow, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, output int cyc, output logic [31:0] res,
                                 output bit busyOk, output bit pulseOk);
        bit d, bz;
        @(negedge clk);
        if (narrow) begin
            b16.func3 = f3; b16.data_in_1 = a[15:0]; b16.data_in_2 = b[15:0]; b16.start = 1'b1;
        end else begin
            b32.func3 = f3; b32.data_in_1 = a; b32.data_in_2 = b; b32.start = 1'b1;
        end
        @(posedge clk); #1;
        b16.start = 1'b0; b32.start = 1'b0;
        b16.data_in_1 = 16'($urandom); b16.data_in_2 = 16'($urandom);
        b32.data_in_1 = $urandom; b32.data_in_2 = $urandom;
        b16.func3 = 3'($urandom); b32.func3 = 3'($urandom);
        cyc = 0; res = '0; busyOk = 1'b1; pulseOk = 1'b0;
        for (int n = 0; n < 100; n++) begin
            d  = narrow ? b16.done : b32.done;
            bz = narrow ? b16.busy : b32.busy;
            if (!bz) busyOk = 1'b0;
            if (d) begin
                cyc = n + 1;
                res = narrow ? {16'h0, b16.data_out} : b32.data_out;
                break;
            end
            @(posedge clk); #1;
        end
        if (cyc != 0) begin
            @(posedge clk); #1;
            pulseOk = narrow ? (!b16.done && !b16.busy) : (!b32.done && !b32.busy);
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] res;
        bit          busyOk, pulseOk, sawDone;
        int          first, second;

        idleInputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset busy", 32'(b32.busy), 32'd0);
        checkOutput("reset done", 32'(b32.done), 32'd0);
        checkOutput("reset data_out", b32.data_out, 32'h0);
        checkOutput("reset zero", 32'(b32.zero), 32'd1);
        checkOutput("reset data_out w16", {16'h0, b16.data_out}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        vecs[0]  = mk(0, 3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        vecs[1]  = mk(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        vecs[2]  = mk(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        vecs[3]  = mk(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        vecs[4]  = mk(0, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
        vecs[5]  = mk(0, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
        vecs[6]  = mk(0, 3'b101, 32'd100, 32'd7, 32'd14, 34);
        vecs[7]  = mk(0, 3'b111, 32'd100, 32'd7, 32'd2, 34);
        vecs[8]  = mk(0, 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        vecs[9]  = mk(0, 3'b110, 32'd5, 32'd0, 32'd5, 1);
        vecs[10] = mk(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        vecs[11] = mk(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        vecs[12] = mk(0, 3'b000, 32'h12345678, 32'd9, 32'hA3D70A38, 34);
        vecs[13] = mk(0, 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        vecs[14] = mk(0, 3'b111, 32'd7, 32'd0, 32'd7, 1);
        vecs[15] = mk(0, 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        vecs[16] = mk(0, 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
        vecs[17] = mk(0, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);
        vecs[18] = mk(1, 3'b000, 32'h0007, 32'hFFFD, 32'hFFEB, 18);
        vecs[19] = mk(1, 3'b001, 32'h8000, 32'h8000, 32'h4000, 18);
        vecs[20] = mk(1, 3'b010, 32'hFFFF, 32'hFFFF, 32'hFFFF, 18);
        vecs[21] = mk(1, 3'b011, 32'hFFFF, 32'hFFFF, 32'hFFFE, 18);
        vecs[22] = mk(1, 3'b100, 32'hFFF9, 32'h0002, 32'hFFFD, 18);
        vecs[23] = mk(1, 3'b110, 32'hFFF9, 32'h0002, 32'hFFFF, 18);
        vecs[24] = mk(1, 3'b101, 32'd100, 32'd7, 32'd14, 18);
        vecs[25] = mk(1, 3'b111, 32'd100, 32'd7, 32'd2, 18);
        vecs[26] = mk(1, 3'b100, 32'd5, 32'd0, 32'hFFFF, 1);
        vecs[27] = mk(1, 3'b110, 32'd5, 32'd0, 32'd5, 1);
        vecs[28] = mk(1, 3'b100, 32'h8000, 32'hFFFF, 32'h8000, 1);
        vecs[29] = mk(1, 3'b110, 32'h8000, 32'hFFFF, 32'h0000, 1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].narrow, vecs[i].f3, vecs[i].a, vecs[i].b,
                          cyc, res, busyOk, pulseOk);
            checkOutput($sformatf("vec%0d result", i), res, vecs[i].exp);
            checkOutput($sformatf("vec%0d done cycle", i), 32'(cyc), 32'(vecs[i].cyc));
            checkOutput($sformatf("vec%0d busy until done", i), 32'(busyOk), 32'd1);
            checkOutput($sformatf("vec%0d single done pulse", i), 32'(pulseOk), 32'd1);
        end

        // Known previous result, then kill a divide at t0+10
        applyStimulus(0, 3'b000, 32'd3, 32'd5, cyc, res, busyOk, pulseOk);
        checkOutput("pre-kill mul", res, 32'd15);
        @(negedge clk);
        b32.func3 = 3'b101; b32.data_in_1 = 32'd1000; b32.data_in_2 = 32'd3; b32.start = 1'b1;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 checkOutput("busy before kill", 32'(b32.busy), 32'd1);
        @(negedge clk); b32.kill = 1'b1;
        @(posedge clk); #1;
        checkOutput("kill busy", 32'(b32.busy), 32'd0);
        checkOutput("kill done", 32'(b32.done), 32'd0);
        @(negedge clk); b32.kill = 1'b0;
        sawDone = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (b32.done) sawDone = 1'b1;
        end
        checkOutput("kill no done", 32'(sawDone), 32'd0);
        checkOutput("kill keeps data_out", b32.data_out, 32'd15);

        // Rejected starts: kill coincident, wrong func7, wrong opcode
        @(negedge clk);
        b32.func3 = 3'b000; b32.data_in_1 = 32'd2; b32.data_in_2 = 32'd2;
        b32.start = 1'b1; b32.kill = 1'b1;
        @(posedge clk); #1;
        checkOutput("start+kill busy", 32'(b32.busy), 32'd0);
        @(negedge clk); b32.kill = 1'b0; b32.func7 = 7'b0000000;
        @(posedge clk); #1;
        checkOutput("bad func7 busy", 32'(b32.busy), 32'd0);
        @(negedge clk); b32.func7 = F7_M; b32.opcode = 7'b0010011;
        sawDone = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (b32.done || b32.busy) sawDone = 1'b1;
        end
        checkOutput("rejected starts idle", 32'(sawDone), 32'd0);
        checkOutput("rejected starts data_out", b32.data_out, 32'd15);

        // Start held high: one op every 35 cycles
        @(negedge clk);
        b32.opcode = OP_R; b32.func3 = 3'b000; b32.data_in_1 = 32'd6; b32.data_in_2 = 32'd7;
        b32.start = 1'b1;
        first = -1; second = -1;
        for (int n = 0; n < 200 && second < 0; n++) begin
            @(posedge clk); #1;
            if (b32.done) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        checkOutput("back-to-back period", 32'(second - first), 32'd35);
        checkOutput("back-to-back result", b32.data_out, 32'd42);
        @(negedge clk); b32.start = 1'b0;
        repeat (40) @(posedge clk);

        // Async reset in the middle of a divide
        @(negedge clk);
        b32.func3 = 3'b100; b32.data_in_1 = 32'h7FFFFFFF; b32.data_in_2 = 32'd3; b32.start = 1'b1;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (19) @(posedge clk);
        #1 checkOutput("busy before reset", 32'(b32.busy), 32'd1);
        checkOutput("zero before reset", 32'(b32.zero), 32'd0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(b32.busy), 32'd0);
        checkOutput("async reset data_out", b32.data_out, 32'h0);
        checkOutput("async reset zero", 32'(b32.zero), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        sawDone = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (b32.done) sawDone = 1'b1;
        end
        checkOutput("no done after reset", 32'(sawDone), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
